// File: rtl/stream_mux_pkg.sv
// Shared types and helpers for the N-channel registered stream mux.
// Mode encodings, output FSM states, modulo index increment.
package stream_mux_pkg;

    localparam int MODE_SEL = 0;
    localparam int MODE_RR  = 1;

    typedef enum logic {
        ST_EMPTY,
        ST_FULL
    } state_t;

    function automatic int idx_next(int idx, int n);
        return (idx + 1 >= n) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/stream_mux_n_if.sv
// Handshake bundle between N producers, the mux and one consumer.
// slave = the mux side, master = the producers/consumer side.
interface stream_mux_n_if #(
    parameter int WIDTH  = 8,
    parameter int NUM_CH = 4
);
    localparam int IDXW = $clog2(NUM_CH);

    logic [NUM_CH*WIDTH-1:0] in_data;
    logic [NUM_CH-1:0]       in_valid;
    logic [NUM_CH-1:0]       in_ready;
    logic [IDXW-1:0]         sel;
    logic [WIDTH-1:0]        out_data;
    logic [IDXW-1:0]         out_ch;
    logic                    out_valid;
    logic                    out_ready;

    modport master (
        output in_data, in_valid, sel, out_ready,
        input  in_ready, out_data, out_ch, out_valid
    );

    modport slave (
        input  in_data, in_valid, sel, out_ready,
        output in_ready, out_data, out_ch, out_valid
    );

endinterface

// File: rtl/stream_mux_n_rr_arbiter.sv
// Round-robin arbiter: first requester at or after ptr wins.
// ptr moves past the winner only when the grant is consumed.
module rr_arbiter
    import stream_mux_pkg::*;
#(
    parameter int NUM_CH = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_CH-1:0]         req,
    input  logic                      advance,
    output logic                      grant_valid,
    output logic [$clog2(NUM_CH)-1:0] grant_idx,
    output logic [$clog2(NUM_CH)-1:0] ptr
);
    localparam int IDXW = $clog2(NUM_CH);

    int              c;
    logic [IDXW-1:0] cand;

    // Scan from farthest to nearest so the nearest hit wins.
    always_comb begin
        grant_valid = 1'b0;
        grant_idx   = '0;
        c           = 0;
        cand        = '0;
        for (int k = NUM_CH - 1; k >= 0; k--) begin
            c = int'(ptr) + k;
            if (c >= NUM_CH) c = c - NUM_CH;
            cand = IDXW'(c);
            if (req[cand]) begin
                grant_valid = 1'b1;
                grant_idx   = cand;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst)
            ptr <= '0;
        else if (advance)
            ptr <= IDXW'(idx_next(int'(grant_idx), NUM_CH));
    end

endmodule

// File: rtl/stream_mux_n.sv
// N-channel registered stream mux, external select or round-robin.
// One output register stage; refills on the same edge it drains.
module stream_mux_n
    import stream_mux_pkg::*;
#(
    parameter int WIDTH  = 8,
    parameter int NUM_CH = 4,
    parameter int MODE   = MODE_SEL
) (
    input  logic           clk,
    input  logic           rst,
    stream_mux_n_if.slave  bus
);
    localparam int IDXW = $clog2(NUM_CH);

    state_t            state_q;
    state_t            state_d;
    logic              can_load;
    logic              take;
    logic              grant_valid;
    logic [IDXW-1:0]   grant_idx;
    logic [IDXW-1:0]   ptr;
    logic [IDXW-1:0]   ch_q;
    logic [WIDTH-1:0]  data_q;
    logic [NUM_CH-1:0] ready;

    assign can_load = (state_q == ST_EMPTY) || bus.out_ready;

    generate
        if (MODE == MODE_RR) begin : g_rr
            logic sel_unused;
            assign sel_unused = ^bus.sel;

            rr_arbiter #(
                .NUM_CH (NUM_CH)
            ) u_arb (
                .clk         (clk),
                .rst         (rst),
                .req         (bus.in_valid),
                .advance     (take),
                .grant_valid (grant_valid),
                .grant_idx   (grant_idx),
                .ptr         (ptr)
            );
        end else begin : g_sel
            // Grant follows sel alone, so ready never waits on valid.
            assign grant_valid = int'(bus.sel) < NUM_CH;
            assign grant_idx   = bus.sel;
            assign ptr         = '0;
        end
    endgenerate

    assign take = grant_valid && bus.in_valid[grant_idx]
                  && can_load && !rst;

    always_comb begin
        ready = '0;
        if (grant_valid && can_load && !rst)
            ready[grant_idx] = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst)
            state_q <= ST_EMPTY;
        else
            state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_EMPTY: if (take) state_d = ST_FULL;
            ST_FULL:  if (!take && bus.out_ready) state_d = ST_EMPTY;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            data_q <= '0;
            ch_q   <= '0;
        end else if (take) begin
            data_q <= bus.in_data[int'(grant_idx)*WIDTH +: WIDTH];
            ch_q   <= grant_idx;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst)
            assert (int'(ptr) < NUM_CH);
    end

    assign bus.in_ready  = ready;
    assign bus.out_valid = (state_q == ST_FULL);
    assign bus.out_data  = data_q;
    assign bus.out_ch    = ch_q;

endmodule

// File: doc/stream_mux_n.md
# stream_mux_n

Parametrised N-channel, W-bit registered stream multiplexer with valid/ready handshakes on every port. It selects one input channel per cycle, either by an external select or by a built-in round-robin arbiter. The chosen beat is captured in a single output register stage. It replaces the fixed 2:1 combinational bit mux wherever several producers share one downstream consumer and back-pressure must be honoured.

## Interface
- WIDTH, 8, data bits per channel (≥1)
- NUM_CH, 4, number of input channels (≥2)
- MODE, 0, 0 = MODE_SEL (external select), 1 = MODE_RR (round-robin)
- IDXW, $clog2(NUM_CH), derived, index width; not to be overridden
- clk  in  1  single clock, all logic on rising edge
- rst  in  1  synchronous, active-high reset
- in_data  in  NUM_CH*WIDTH  channel i occupies bits [i*WIDTH +: WIDTH]
- in_valid  in  NUM_CH  per-channel valid
- in_ready  out  NUM_CH  per-channel ready; at most one bit high per cycle
- sel  in  IDXW  channel select, used only in MODE_SEL
- out_data  out  WIDTH  registered output beat
- out_ch  out  IDXW  source channel index of out_data
- out_valid  out  1  output register holds a beat
- out_ready  in  1  downstream accepts

## Operation
- Output register FSM: EMPTY (out_valid=0) and FULL (out_valid=1).
- can_load = !out_valid || out_ready.
- Grant, combinational:
  - MODE_SEL: grant = sel if sel < NUM_CH, else none.
  - MODE_RR: first channel with in_valid=1, searching ptr, ptr+1, … wrapping modulo NUM_CH.
- in_ready[g] = can_load for the granted channel g. All other bits are 0. In MODE_SEL, in_ready[sel] does not depend on in_valid[sel].
- Input transfer occurs when in_valid[g] && in_ready[g]. The register loads in_data slice g and out_ch=g, and out_valid stays or goes to 1.
- Output transfer (out_valid && out_ready) with no input transfer: out_valid goes to 0. out_data and out_ch keep their last values.
- Simultaneous output and input transfer: the register is overwritten with the new beat and out_valid stays 1. No bubble.
- Stall (out_valid && !out_ready): out_data, out_ch and out_valid are held stable. in_ready is all 0.
- Round-robin pointer ptr (IDXW bits) advances only on an input transfer: ptr = (g+1) mod NUM_CH. When g = NUM_CH-1, ptr wraps to 0. For non-power-of-2 NUM_CH, the wrap is explicit and never reaches NUM_CH.
- No valid inputs: no grant, and ptr is unchanged.
- ptr is unused in MODE_SEL and stays at 0.

## Timing
- Latency: 1 cycle from input transfer edge to out_valid=1 with the data.
- Throughput: 1 beat/cycle while out_ready=1.
- Reset values: out_valid=0, out_data=0, out_ch=0, ptr=0, FSM=EMPTY.
- in_ready is all 0 during the reset cycle.
- Reset asserted while FULL: the beat is dropped with no output transfer. Reset overrides any same-cycle transfer.
- in_ready is combinational from out_valid, out_ready, sel/in_valid and ptr. There is no path from in_ready back to in_valid.
- in_data of non-granted channels has no effect.

## Structure
- Package stream_mux_pkg holds:
  - localparams MODE_SEL=0 and MODE_RR=1;
  - function idx_next(idx, n) implementing the modulo-n increment.
- Sub-module rr_arbiter (parameter NUM_CH). It takes req[NUM_CH], ptr and advance, and produces grant_valid, grant_idx and the registered ptr. It is instantiated only when MODE==MODE_RR (generate).
- The top level contains the output register, FSM, MODE_SEL decode and data slice select.

## Test plan
- Reset: hold rst=1 for 2 cycles with all in_valid=1 -> out_valid=0, out_data=0, in_ready=0; after release, first grant is channel 0.
- MODE_SEL pass-through: sel=2, in_valid=4'b0100, ch2 data 8'hA5, out_ready=1 -> next cycle out_valid=1, out_data=8'hA5, out_ch=2; other in_ready bits 0 throughout.
- Back-pressure: FULL with 8'h11, out_ready=0 for 3 cycles while ch1 valid with 8'h22 -> out_data held at 8'h11, in_ready=0; on out_ready=1, 8'h22 loads the next cycle with no bubble.
- Round-robin fairness (MODE_RR, NUM_CH=4): all in_valid=1, out_ready=1 for 8 cycles -> out_ch sequence 0,1,2,3,0,1,2,3.
- Skip and wrap (MODE_RR): only ch3 and ch1 valid, ptr=0 -> grants 1,3,1,3; with NUM_CH=3, ptr after a ch2 grant is 0.
- Reset mid-stream: assert rst while FULL and out_ready=0 -> the beat is discarded, out_valid=0 the next cycle, ptr=0.
